// File: rtl/buffer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// buffer_ctrl_pkg
// Shared types and constants for the endpoint data buffer controller.
//   buf_op_t    : op encoding understood by the 64x8 register file
//   requester_t : identifies the two buffer requesters (A = AHB, B = USB)
//   ctrl_state_t: controller FSM states (SCRUB only used with BUFFER_SCRUB_EN)
// -----------------------------------------------------------------------------
package buffer_ctrl_pkg;

   localparam int BUF_DEPTH = 64;
   localparam int BUF_PTR_W = 6;

   typedef enum logic [1:0] {
      NOP   = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } buf_op_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } requester_t;

   typedef enum logic {
      RUN   = 1'b0,
      SCRUB = 1'b1
   } ctrl_state_t;

endpackage

// File: rtl/data_buffer_controller_arb.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin arbiter with eligibility masking.
//   clk, n_rst : clock, asynchronous active-low reset
//   hold       : suppress all grants this cycle (flush / scrub)
//   elig[1:0]  : eligible requests, bit 0 = port A, bit 1 = port B
//   grant[1:0] : one-hot (or zero) grant, combinational from elig
// Priority starts at A and always passes to the port that did not win.
// -----------------------------------------------------------------------------
module rr_arbiter_2
   import buffer_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       n_rst,
   input  logic       hold,
   input  logic [1:0] elig,
   output logic [1:0] grant
);

   requester_t prio;

   always_comb begin
      grant = 2'b00;
      if (!hold) begin
         case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (prio == REQ_A) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   // A sole winner hands priority over just like a contended win does.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         prio <= REQ_A;
      else if (grant[0])
         prio <= REQ_B;
      else if (grant[1])
         prio <= REQ_A;
   end

endmodule

// File: rtl/data_buffer_controller.sv
// -----------------------------------------------------------------------------
// data_buffer_controller
// Sequencer/arbiter for the 64x8 endpoint data buffer register file. Shares the
// buffer as a FIFO between port A (AHB slave) and port B (USB protocol side).
//
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   flush                 synchronous clear of pointers and occupancy
//   a_req/a_wr/a_wdata    port A request (held until a_grant), 1=write
//   a_grant               port A accepted this cycle
//   a_rdata/a_rvalid      port A read byte, valid pulse one cycle after grant
//   b_*                   same set for port B
//   rf_op                 NOP/WRITE/READ to the register file
//   rf_write_data/_pointer, rf_read_pointer   register file address/data
//   rf_read_data          register file read byte, combinational
//   occupancy/empty/full  FIFO status
//   busy                  scrub in progress
//
// Optional feature macro BUFFER_SCRUB_EN: flush additionally zero-fills every
// buffer entry (one per cycle) before grants resume. Without it busy is 0.
// -----------------------------------------------------------------------------
module data_buffer_controller
   import buffer_ctrl_pkg::*;
#(
   parameter int DEPTH  = BUF_DEPTH,
   parameter int PTR_W  = BUF_PTR_W,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              flush,
   input  logic              a_req,
   input  logic              a_wr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_grant,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_rvalid,
   input  logic              b_req,
   input  logic              b_wr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_grant,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_rvalid,
   output logic [1:0]        rf_op,
   output logic [DATA_W-1:0] rf_write_data,
   output logic [PTR_W-1:0]  rf_write_pointer,
   output logic [PTR_W-1:0]  rf_read_pointer,
   input  logic [DATA_W-1:0] rf_read_data,
   output logic [PTR_W:0]    occupancy,
   output logic              empty,
   output logic              full,
   output logic              busy
);

   logic [PTR_W-1:0]  wptr, rptr;
   logic [PTR_W:0]    occ;
   logic [1:0]        elig, grant;
   logic              scrubbing, scrub_wr;
   logic [PTR_W-1:0]  scrub_cnt;
   logic              win_wr, do_wr, do_rd;
   logic [DATA_W-1:0] win_wdata;
   buf_op_t           op;

   assign occupancy = occ;
   assign empty     = (occ == '0);
   assign full      = (occ == (PTR_W+1)'(DEPTH));

   // Ineligible requests simply stay pending; they never reach the arbiter.
   assign elig[0] = a_req && (a_wr ? !full : !empty);
   assign elig[1] = b_req && (b_wr ? !full : !empty);

   rr_arbiter_2 u_arb (
      .clk   (clk),
      .n_rst (n_rst),
      .hold  (flush || scrubbing),
      .elig  (elig),
      .grant (grant)
   );

   assign a_grant   = grant[0];
   assign b_grant   = grant[1];
   assign win_wr    = grant[0] ? a_wr : b_wr;
   assign win_wdata = grant[0] ? a_wdata : b_wdata;
   assign do_wr     = (|grant) && win_wr;
   assign do_rd     = (|grant) && !win_wr;

`ifdef BUFFER_SCRUB_EN
   ctrl_state_t state, state_nxt;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= RUN;
         scrub_cnt <= '0;
      end else begin
         state <= state_nxt;
         // flush (re)starts the sweep from address 0
         if (flush)
            scrub_cnt <= '0;
         else if (state == SCRUB)
            scrub_cnt <= scrub_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (flush) state_nxt = SCRUB;
         SCRUB:   if (!flush && scrub_cnt == PTR_W'(DEPTH-1)) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   assign scrubbing = (state == SCRUB);
   // A flush landing mid-scrub still yields a NOP cycle.
   assign scrub_wr  = scrubbing && !flush;
   assign busy      = scrubbing;
`else
   assign scrubbing = 1'b0;
   assign scrub_wr  = 1'b0;
   assign scrub_cnt = '0;
   assign busy      = 1'b0;
`endif

   // Pointer outputs idle at the current wptr/rptr so the register file
   // always sees a meaningful address.
   always_comb begin
      op               = NOP;
      rf_write_data    = '0;
      rf_write_pointer = wptr;
      rf_read_pointer  = rptr;
      if (scrub_wr) begin
         op               = WRITE;
         rf_write_pointer = scrub_cnt;
      end else if (do_wr) begin
         op            = WRITE;
         rf_write_data = win_wdata;
      end else if (do_rd) begin
         op = READ;
      end
   end

   assign rf_op = op;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wptr <= '0;
         rptr <= '0;
         occ  <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
         occ  <= '0;
      end else if (do_wr) begin
         wptr <= wptr + 1'b1;
         occ  <= occ + 1'b1;
      end else if (do_rd) begin
         rptr <= rptr + 1'b1;
         occ  <= occ - 1'b1;
      end
   end

   // Read data is captured in the READ cycle; rvalid is not gated by flush so
   // a read granted just before a flush still completes.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         a_rdata  <= '0;
         a_rvalid <= 1'b0;
         b_rdata  <= '0;
         b_rvalid <= 1'b0;
      end else begin
         a_rvalid <= grant[0] && !a_wr;
         b_rvalid <= grant[1] && !b_wr;
         if (grant[0] && !a_wr) a_rdata <= rf_read_data;
         if (grant[1] && !b_wr) b_rdata <= rf_read_data;
      end
   end

endmodule

// File: tb/tb_data_buffer_controller.sv
// -----------------------------------------------------------------------------
// tb_data_buffer_controller
// Directed bench with a scoreboard: a reference FIFO holds written bytes; each
// read grant moves the expected byte into the granted port's queue, and the
// monitor compares it when that port's rvalid fires. Includes a behavioural
// 64x8 register file. Builds with or without BUFFER_SCRUB_EN.
// -----------------------------------------------------------------------------
module tb_data_buffer_controller;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       flush;
   logic       a_req, a_wr, b_req, b_wr;
   logic [7:0] a_wdata, b_wdata;
   logic       a_grant, b_grant, a_rvalid, b_rvalid;
   logic [7:0] a_rdata, b_rdata;
   logic [1:0] rf_op;
   logic [7:0] rf_write_data, rf_read_data;
   logic [5:0] rf_write_pointer, rf_read_pointer;
   logic [6:0] occupancy;
   logic       empty, full, busy;

   int n_cmp = 0;
   int n_err = 0;
   bit mon_en = 1'b0;

   logic [7:0] mem [64];
   logic [7:0] mfifo [$];
   logic [7:0] a_q [$];
   logic [7:0] b_q [$];
   int exp_wptr = 0;
   int exp_rptr = 0;

   always #5 clk = ~clk;

   data_buffer_controller dut (
      .clk(clk), .n_rst(n_rst), .flush(flush),
      .a_req(a_req), .a_wr(a_wr), .a_wdata(a_wdata), .a_grant(a_grant),
      .a_rdata(a_rdata), .a_rvalid(a_rvalid),
      .b_req(b_req), .b_wr(b_wr), .b_wdata(b_wdata), .b_grant(b_grant),
      .b_rdata(b_rdata), .b_rvalid(b_rvalid),
      .rf_op(rf_op), .rf_write_data(rf_write_data),
      .rf_write_pointer(rf_write_pointer), .rf_read_pointer(rf_read_pointer),
      .rf_read_data(rf_read_data),
      .occupancy(occupancy), .empty(empty), .full(full), .busy(busy)
   );

   // register file model
   always @(posedge clk)
      if (rf_op == 2'd1) mem[rf_write_pointer] <= rf_write_data;
   assign rf_read_data = mem[rf_read_pointer];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (mon_en) begin
         if (a_rvalid) begin
            if (a_q.size() == 0) chk("a_rvalid_spurious", 1, 0);
            else chk("a_rdata", a_rdata, a_q.pop_front());
         end
         if (b_rvalid) begin
            if (b_q.size() == 0) chk("b_rvalid_spurious", 1, 0);
            else chk("b_rdata", b_rdata, b_q.pop_front());
         end
         if (a_grant && b_grant) chk("double_grant", 1, 0);
         if (a_grant) begin
            if (a_wr) mfifo.push_back(a_wdata);
            else if (mfifo.size() == 0) chk("a_read_when_empty", 1, 0);
            else a_q.push_back(mfifo.pop_front());
         end else if (b_grant) begin
            if (b_wr) mfifo.push_back(b_wdata);
            else if (mfifo.size() == 0) chk("b_read_when_empty", 1, 0);
            else b_q.push_back(mfifo.pop_front());
         end
         if (flush) mfifo.delete();
      end
   end

   task automatic set_req(input bit p, input bit req, input bit wr, input logic [7:0] d);
      if (p == 1'b0) begin a_req = req; a_wr = wr; a_wdata = d; end
      else           begin b_req = req; b_wr = wr; b_wdata = d; end
   endtask

   // Waits (bounded) on the next negedges for a grant to port p.
   task automatic wait_grant(input bit p, output bit ok);
      int n = 0;
      @(negedge clk);
      while (!(p ? b_grant : a_grant) && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = p ? b_grant : a_grant;
      if (!ok) chk("grant_timeout", 0, 1);
   endtask

   // Called and returns at posedge+1.
   task automatic do_write(input bit p, input logic [7:0] d);
      bit ok;
      set_req(p, 1'b1, 1'b1, d);
      wait_grant(p, ok);
      if (ok) begin
         chk("wr_op", rf_op, 1);
         chk("wr_ptr", rf_write_pointer, exp_wptr);
         chk("wr_data", rf_write_data, d);
         exp_wptr = (exp_wptr + 1) % 64;
      end
      @(posedge clk); #1;
      set_req(p, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic do_read(input bit p);
      bit ok;
      set_req(p, 1'b1, 1'b0, 8'h00);
      wait_grant(p, ok);
      if (ok) begin
         chk("rd_op", rf_op, 2);
         chk("rd_ptr", rf_read_pointer, exp_rptr);
         exp_rptr = (exp_rptr + 1) % 64;
      end
      @(posedge clk); #1;
      set_req(p, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      chk("rvalid_latency", p ? b_rvalid : a_rvalid, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 8'hFF;
      n_rst = 1'b0; flush = 1'b0;
      a_req = 0; a_wr = 0; a_wdata = 0; b_req = 0; b_wr = 0; b_wdata = 0;
      repeat (3) @(negedge clk);
      chk("rst_occ", occupancy, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rf_op", rf_op, 0);
      chk("rst_wptr", rf_write_pointer, 0);
      chk("rst_rptr", rf_read_pointer, 0);
      chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
      @(posedge clk); #1;
      n_rst = 1'b1;
      mon_en = 1'b1;

      // A writes three bytes back to back, B reads them back
      do_write(0, 8'h11); do_write(0, 8'h22); do_write(0, 8'h33);
      chk("occ_after_3wr", occupancy, 3);
      do_read(1); do_read(1); do_read(1);
      chk("occ_after_3rd", occupancy, 0);

      // B fills to 5 (priority ends at A), then A write / B read contend
      for (int i = 0; i < 5; i++) do_write(1, 8'h40 + 8'(i));
      chk("occ5", occupancy, 5);
      set_req(0, 1'b1, 1'b1, 8'h50);
      set_req(1, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("alt_a_grant", a_grant, (i % 2 == 0));
         chk("alt_b_grant", b_grant, (i % 2 == 1));
         chk("alt_op", rf_op, (i % 2 == 0) ? 1 : 2);
         if (i % 2 == 0) exp_wptr++; else exp_rptr++;
         @(posedge clk); #1;
         if (i % 2 == 0) a_wdata = a_wdata + 8'h01;
         chk("alt_occ", occupancy, (i % 2 == 0) ? 6 : 5);
      end
      set_req(0, 1'b0, 1'b0, 8'h00);
      set_req(1, 1'b0, 1'b0, 8'h00);

      // occupancy 10, then flush with a pending A write
      for (int i = 0; i < 5; i++) do_write(0, 8'h60 + 8'(i));
      chk("occ10", occupancy, 10);
      flush = 1'b1;
      set_req(0, 1'b1, 1'b1, 8'h70);
      @(negedge clk);
      chk("flush_no_grant", a_grant, 0);
      chk("flush_nop", rf_op, 0);
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_occ", occupancy, 0);
      chk("flush_empty", empty, 1);
      exp_wptr = 0; exp_rptr = 0;
`ifdef BUFFER_SCRUB_EN
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         chk("scrub_busy", busy, 1);
         chk("scrub_op", rf_op, 1);
         chk("scrub_addr", rf_write_pointer, i);
         chk("scrub_data", rf_write_data, 0);
         chk("scrub_no_grant", a_grant, 0);
      end
`endif
      @(negedge clk);
      chk("post_flush_busy", busy, 0);
      chk("post_flush_grant", a_grant, 1);
      chk("post_flush_ptr", rf_write_pointer, 0);
      chk("post_flush_rptr", rf_read_pointer, 0);
      exp_wptr = 1;
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, 8'h00);
`ifdef BUFFER_SCRUB_EN
      chk("scrub_mem_last", mem[63], 0);
`endif

      // fill to full; a 65th write must wait
      for (int i = 0; i < 63; i++) do_write(0, 8'h80 + 8'(i));
      chk("full_flag", full, 1);
      chk("full_occ", occupancy, 64);
      set_req(0, 1'b1, 1'b1, 8'hEE);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("full_no_grant", a_grant, 0);
         chk("full_nop", rf_op, 0);
         @(posedge clk); #1;
      end
      set_req(1, 1'b1, 1'b0, 8'h00);
      @(negedge clk);
      chk("full_rd_grant", b_grant, 1);
      chk("full_rd_ptr", rf_read_pointer, 0);
      @(posedge clk); #1;
      set_req(1, 1'b0, 1'b0, 8'h00);
      exp_rptr = 1;
      @(negedge clk);
      chk("wrap_wr_grant", a_grant, 1);
      chk("wrap_wr_ptr", rf_write_pointer, 0);
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, 8'h00);
      chk("wrap_mem0", mem[0], 8'hEE);
      exp_wptr = 1;

      // drain everything
      for (int i = 0; i < 64; i++) do_read(1);
      chk("drain_empty", empty, 1);

      // read while empty, then a write unblocks it
      set_req(1, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("empty_no_grant", b_grant, 0);
         chk("empty_no_rvalid", b_rvalid, 0);
         @(posedge clk); #1;
      end
      set_req(0, 1'b1, 1'b1, 8'hA5);
      @(negedge clk);
      chk("a5_wr_grant", a_grant, 1);
      chk("a5_rd_wait", b_grant, 0);
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      chk("a5_rd_grant", b_grant, 1);
      chk("a5_rd_op", rf_op, 2);
      @(posedge clk); #1;
      set_req(1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      chk("a5_rvalid", b_rvalid, 1);
      chk("a5_empty", empty, 1);

      repeat (3) @(negedge clk);
      chk("a_q_drained", a_q.size(), 0);
      chk("b_q_drained", b_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/data_buffer_controller.md
Name: data_buffer_controller

Overview:
- Sequencer and arbiter for the 64x8 endpoint data buffer register file. The register file accepts one op per cycle: NOP=0, WRITE=1, READ=2.
- Shares the buffer between two requesters: port A (AHB-lite slave side) and port B (USB RX/TX protocol side).
- Maintains FIFO read/write pointers, occupancy and full/empty status, and handles flush.
- Drives the register file's op, write_data, read_pointer and write_pointer inputs, and captures its read_data output.

Parameters:
- DEPTH, 64, buffer entries; must be a power of 2.
- PTR_W, 6, pointer width, equal to log2(DEPTH).
- DATA_W, 8, byte width.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous clear of pointers and occupancy
- a_req  in  1  port A request; held until a_grant
- a_wr  in  1  port A direction: 1=write, 0=read
- a_wdata  in  DATA_W  port A write byte
- a_grant  out  1  port A request accepted this cycle
- a_rdata  out  DATA_W  port A read byte
- a_rvalid  out  1  a_rdata valid (one-cycle pulse)
- b_req, b_wr, b_wdata, b_grant, b_rdata, b_rvalid: identical set for port B
- rf_op  out  2  op to register file
- rf_write_data  out  DATA_W  to register file
- rf_write_pointer  out  PTR_W  to register file
- rf_read_pointer  out  PTR_W  to register file
- rf_read_data  in  DATA_W  from register file; combinational, valid in the READ cycle
- occupancy  out  PTR_W+1  stored bytes, range 0..DEPTH
- empty  out  1  occupancy==0
- full  out  1  occupancy==DEPTH
- busy  out  1  scrub in progress; 0 when the scrub feature is compiled out

Behaviour:
- Reset values:
  - wptr=0, rptr=0, occupancy=0, empty=1, full=0, busy=0.
  - a/b_rdata=0, a/b_rvalid=0, RR priority=A, FSM=RUN.
  - rf_op=NOP, all rf pointers and data=0.
- Eligibility:
  - A write request is eligible only if !full.
  - A read request is eligible only if !empty.
  - Ineligible requests stay pending and ungranted; there is no error and no op.
- Arbitration (combinational, same cycle as request):
  - Only eligible requests are considered; at most one grant per cycle.
  - If exactly one eligible request exists, it is granted.
  - If both are eligible, the port holding RR priority wins; priority then passes to the loser.
  - A sole winner also passes priority to the other port.
- Granted write:
  - rf_op=WRITE, rf_write_pointer=wptr, rf_write_data=winner wdata.
  - wptr<=wptr+1, wrapping 63->0; occupancy+1.
- Granted read:
  - rf_op=READ, rf_read_pointer=rptr.
  - Winner's rdata<=rf_read_data, and rvalid=1 in the next cycle: read latency 1.
  - rptr<=rptr+1, wrapping; occupancy-1.
- No grant: rf_op=NOP; rf pointer outputs continue to show current wptr/rptr.
- Occupancy changes by exactly ±1 per cycle at most. Simultaneous read and write never occur because there is a single grant.
- Flush:
  - wptr, rptr and occupancy clear to 0 at the next edge.
  - Flush has priority: no grant and rf_op=NOP in the flush cycle. Pending requests are re-arbitrated afterwards.
  - An rvalid already scheduled from the previous cycle still fires.
- FSM:
  - RUN: normal operation.
  - SCRUB: exists only with the optional feature; see below.
- An n_rst assertion at any time returns every state element to its reset value immediately.

Optional Feature:
- Macro: BUFFER_SCRUB_EN.
- Defined:
  - flush moves the FSM from RUN to SCRUB. Pointers clear as usual, and busy=1.
  - SCRUB issues WRITE with data 0 to addresses 0..DEPTH-1, one per cycle (DEPTH cycles), using an internal counter.
  - No grants are issued during SCRUB. After address DEPTH-1 is written, the FSM returns to RUN and busy=0.
  - flush during SCRUB restarts the scrub counter at 0.
- Undefined: the SCRUB state and counter are absent, busy is tied to 0, and flush clears pointers only.

Decomposition:
- Package buffer_ctrl_pkg contains:
  - enum buf_op_t {NOP=2'd0, WRITE=2'd1, READ=2'd2}, shared with the register file;
  - enum requester_t {REQ_A, REQ_B};
  - constants BUF_DEPTH=64 and BUF_PTR_W=6.
- Sub-module rr_arbiter_2: a 2-way round-robin arbiter with eligibility masking and a priority flop.

Test Plan:
- After reset: A writes 0x11, 0x22, 0x33 on consecutive cycles -> a_grant each cycle, rf_op=WRITE, rf_write_pointer 0,1,2, occupancy=3. B reads 3 times -> b_rdata 0x11, 0x22, 0x33, each one cycle after its b_grant.
- a_req write and b_req read both held with occupancy=5 -> grants alternate A,B,A,B (A first after reset); occupancy oscillates 6,5,6,5.
- Write 64 bytes -> full=1, occupancy=64. A 65th write stays ungranted for 10 cycles with rf_op=NOP. One read -> the write is granted next cycle, wptr wraps to 0 and the byte lands at address 0.
- Read with empty=1 -> no grant and no rvalid. Write 0xA5 -> next-cycle read returns 0xA5 and empty returns to 1.
- occupancy=10 with flush and a_req both high -> no grant; occupancy=0, wptr=0 and rptr=0 next cycle. A is granted in the following cycle.
- With BUFFER_SCRUB_EN: flush -> busy=1 for 64 cycles with rf_op=WRITE, data 0, addresses 0..63, and requests ignored; then busy=0. A read of any location after refilling is unaffected by stale data.
